vga_timing_gen: RTL and testbench

VGA raster timing generator, directly downstream of the board clock generator. Runs in the `clk_in` domain and advances one pixel per rising edge of the divided `pix_clk` it receives. Gates start-up on `pll_locked`. Produces the sync, data-enable, pixel-coordinate and line/frame strobes for the video output stage, plus a linear framebuffer read address for the frame store.

---
 rtl/vga_timing_gen.sv | 206 ++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: steps one pixel per pix_clk rising edge in the clk_in domain.
// Define VGA_TIMING_PREFETCH_EN to run the framebuffer fetch position FETCH_LEAD pixels ahead.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter logic        SYNC_POL   = 1'b0,
    parameter int unsigned FETCH_LEAD = 2
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        pix_clk,
    input  logic        pll_locked,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [9:0]  hcount,
    output logic [9:0]  vcount,
    output logic        line_start,
    output logic        frame_start,
    output logic        fb_rd,
    output logic [18:0] fb_addr
);

    localparam int unsigned L_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned L_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  L_H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0]  L_H_LAST    = 10'(L_H_TOTAL - 1);
    localparam logic [9:0]  L_HS_FIRST  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  L_HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  L_V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0]  L_V_LAST    = 10'(L_V_TOTAL - 1);
    localparam logic [9:0]  L_VS_FIRST  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  L_VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [18:0] L_ADDR_LAST = 19'(H_ACTIVE * V_ACTIVE - 1);

    if (FETCH_LEAD == 0 || FETCH_LEAD > H_FP) begin : g_lead_check
        $error("vga_timing_gen: FETCH_LEAD must lie in 1..H_FP");
    end

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_pix_clk_d;
    logic        w_pix_ce;
    logic        w_start, w_step, w_run_nxt;

    logic [9:0]  r_hcount, r_vcount, w_hcount_nxt, w_vcount_nxt;
    logic [9:0]  w_fh_nxt, w_fv_nxt;
    logic        r_hsync, r_vsync, r_de, r_line_start, r_frame_start, r_fb_rd;
    logic        w_hsync_nxt, w_vsync_nxt, w_de_nxt, w_line_start_nxt, w_frame_start_nxt, w_fb_rd_nxt;
    logic [18:0] r_fb_addr, w_fb_addr_nxt;

    function automatic logic [19:0] f_step(input logic [9:0] h, input logic [9:0] v);
        logic [9:0] h_n;
        logic [9:0] v_n;
        h_n = h + 10'd1;
        v_n = v;
        if (h == L_H_LAST) begin
            h_n = '0;
            v_n = (v == L_V_LAST) ? '0 : v + 10'd1;
        end
        return {v_n, h_n};
    endfunction

    assign w_pix_ce = pix_clk & ~r_pix_clk_d;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_hcount_nxt = r_hcount;
        w_vcount_nxt = r_vcount;
        w_start      = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pix_ce && pll_locked) begin
                    w_state_nxt  = S_RUN;
                    w_start      = 1'b1;
                    w_hcount_nxt = '0;
                    w_vcount_nxt = L_V_ACT;
                end
            end
            S_RUN: begin
                // Loss of lock wins over a coincident pixel strobe.
                if (!pll_locked) begin
                    w_state_nxt  = S_IDLE;
                    w_hcount_nxt = '0;
                    w_vcount_nxt = '0;
                end else if (w_pix_ce) begin
                    w_step = 1'b1;
                    {w_vcount_nxt, w_hcount_nxt} = f_step(r_hcount, r_vcount);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_run_nxt = (w_state_nxt == S_RUN);

`ifdef VGA_TIMING_PREFETCH_EN
    localparam logic [9:0] L_FETCH_H0 = 10'(FETCH_LEAD);

    logic [9:0] r_fh, r_fv;

    always_comb begin
        w_fh_nxt = r_fh;
        w_fv_nxt = r_fv;
        if (!w_run_nxt) begin
            w_fh_nxt = '0;
            w_fv_nxt = '0;
        end else if (w_start) begin
            w_fh_nxt = L_FETCH_H0;
            w_fv_nxt = L_V_ACT;
        end else if (w_step) begin
            {w_fv_nxt, w_fh_nxt} = f_step(r_fh, r_fv);
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_fh <= '0;
            r_fv <= '0;
        end else begin
            r_fh <= w_fh_nxt;
            r_fv <= w_fv_nxt;
        end
    end
`else
    assign w_fh_nxt = w_hcount_nxt;
    assign w_fv_nxt = w_vcount_nxt;
`endif

    always_comb begin
        w_de_nxt          = w_run_nxt && (w_hcount_nxt < L_H_ACT) && (w_vcount_nxt < L_V_ACT);
        w_hsync_nxt       = (w_run_nxt && w_hcount_nxt >= L_HS_FIRST && w_hcount_nxt <= L_HS_LAST)
                            ? SYNC_POL : ~SYNC_POL;
        w_vsync_nxt       = (w_run_nxt && w_vcount_nxt >= L_VS_FIRST && w_vcount_nxt <= L_VS_LAST)
                            ? SYNC_POL : ~SYNC_POL;
        w_line_start_nxt  = w_start || (w_step && w_hcount_nxt == '0);
        w_frame_start_nxt = w_step && (w_hcount_nxt == '0) && (w_vcount_nxt == '0);
        w_fb_rd_nxt       = w_run_nxt && (w_fh_nxt < L_H_ACT) && (w_fv_nxt < L_V_ACT);

        // Address follows the fetch position incrementally and parks on the last pixel.
        w_fb_addr_nxt = r_fb_addr;
        if (!w_run_nxt) begin
            w_fb_addr_nxt = '0;
        end else if (w_step) begin
            if (w_fh_nxt == '0 && w_fv_nxt == '0) begin
                w_fb_addr_nxt = '0;
            end else if (r_fb_rd && r_fb_addr != L_ADDR_LAST) begin
                w_fb_addr_nxt = r_fb_addr + 19'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_pix_clk_d   <= 1'b1;
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_de          <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_fb_rd       <= 1'b0;
            r_fb_addr     <= '0;
        end else begin
            r_pix_clk_d   <= pix_clk;
            r_hcount      <= w_hcount_nxt;
            r_vcount      <= w_vcount_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_de          <= w_de_nxt;
            r_line_start  <= w_line_start_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_fb_rd       <= w_fb_rd_nxt;
            r_fb_addr     <= w_fb_addr_nxt;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign fb_rd       = r_fb_rd;
    assign fb_addr     = r_fb_addr;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced 32x15 raster (16x8 visible), pix_clk = clk_in/4.
module tb_vga_timing_gen;

    localparam int HA = 16, HFP = 4, HS = 6, HBP = 6, HT = 32;
    localparam int VA = 8,  VFP = 2, VS = 2, VBP = 3, VT = 15;
`ifdef VGA_TIMING_PREFETCH_EN
    localparam int LEAD = 2;
`else
    localparam int LEAD = 0;
`endif

    logic        clk_in = 1'b0;
    logic        rst = 1'b0;
    logic        pll_locked = 1'b0;
    logic [1:0]  pdiv = 2'd0;
    logic        pix_clk;
    logic        hsync, vsync, de, line_start, frame_start, fb_rd;
    logic [9:0]  hcount, vcount;
    logic [18:0] fb_addr;

    int n_chk = 0, n_err = 0, cyc = 0;
    int n_de, n_hs, n_vs, n_ls, n_fs, n_rd, n_hfall, n_vfall;
    int bad_strobe, bad_stable, bad_de, bad_hs, bad_vs, bad_fb, bad_hfall, bad_vfall;
    int last_fs, fs_gap;
    logic        prev_hs, prev_vs;
    logic [42:0] prev_vec;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(1'b0), .FETCH_LEAD(2)
    ) dut (
        .clk_in(clk_in), .rst(rst), .pix_clk(pix_clk), .pll_locked(pll_locked),
        .hsync(hsync), .vsync(vsync), .de(de), .hcount(hcount), .vcount(vcount),
        .line_start(line_start), .frame_start(frame_start), .fb_rd(fb_rd), .fb_addr(fb_addr)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) pdiv <= pdiv + 2'd1;
    assign pix_clk = pdiv[1];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
        cyc++;
    endtask

    function automatic int outs_reset();
        return int'(hsync && vsync && !de && !fb_rd && !line_start && !frame_start &&
                    hcount == 10'd0 && vcount == 10'd0 && fb_addr == 19'd0);
    endfunction

    task automatic wait_frame(input int budget, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!frame_start && cycles < budget);
        if (!frame_start) cycles = -1;
    endtask

    task automatic wait_pos(input int h, input int v, input int ph, input int budget, output int found);
        found = 0;
        for (int i = 0; i < budget && found == 0; i++) begin
            tick();
            if (int'(hcount) == h && int'(vcount) == v && int'(pdiv) == ph) found = 1;
        end
    endtask

    task automatic wait_update(input int budget, output int found);
        found = 0;
        for (int i = 0; i < budget && found == 0; i++) begin
            tick();
            if (line_start) found = 1;
        end
    endtask

    task automatic observe();
        int h, v, fh, fv;
        logic exp_rd;
        h = int'(hcount);
        v = int'(vcount);
        if (pdiv != 2'd3) begin
            if (line_start || frame_start) bad_strobe++;
            if ({hsync, vsync, de, fb_rd, hcount, vcount, fb_addr} != prev_vec) bad_stable++;
        end else begin
            if (frame_start && !line_start) bad_strobe++;
            if (line_start) n_ls++;
            if (frame_start) begin
                n_fs++;
                if (last_fs >= 0) fs_gap = cyc - last_fs;
                last_fs = cyc;
            end
            if (de) n_de++;
            if (fb_rd) n_rd++;
            if (de != (h < HA && v < VA)) bad_de++;
            if (!hsync) n_hs++;
            if (!vsync) n_vs++;
            if (!hsync != (h >= HA + HFP && h <= HA + HFP + HS - 1)) bad_hs++;
            if (!vsync != (v >= VA + VFP && v <= VA + VFP + VS - 1)) bad_vs++;
            if (!hsync && prev_hs) begin
                n_hfall++;
                if (h != HA + HFP) bad_hfall++;
            end
            if (!vsync && prev_vs) begin
                n_vfall++;
                if (v != VA + VFP || h != 0) bad_vfall++;
            end
            fh = h + LEAD;
            fv = v;
            if (fh >= HT) begin
                fh -= HT;
                fv++;
                if (fv >= VT) fv = 0;
            end
            exp_rd = (fh < HA && fv < VA);
            if (fb_rd != exp_rd) bad_fb++;
            else if (exp_rd && int'(fb_addr) != fv * HA + fh) bad_fb++;
`ifdef VGA_TIMING_PREFETCH_EN
            if (h == HT - 2 && v == VT - 1) begin
                check("pf_rise_rd", int'(fb_rd), 1);
                check("pf_rise_addr", int'(fb_addr), 0);
            end
            if (h == HA - 3 && v == 0) check("pf_last_rd", int'(fb_rd), 1);
            if (h == HA - 2 && v == 0) check("pf_fall_rd", int'(fb_rd), 0);
`else
            if (h == 0 && v == 0) begin
                check("addr_0_0", int'(fb_addr), 0);
                check("rd_0_0", int'(fb_rd), 1);
            end
            if (h == HA - 1 && v == 0) check("addr_15_0", int'(fb_addr), 15);
            if (h == 0 && v == 1) check("addr_0_1", int'(fb_addr), 16);
            if (h == HA - 1 && v == VA - 1) check("addr_last", int'(fb_addr), 127);
`endif
            prev_hs = hsync;
            prev_vs = vsync;
        end
        prev_vec = {hsync, vsync, de, fb_rd, hcount, vcount, fb_addr};
    endtask

    initial begin
        int bad, found, cycles;

        rst = 1'b0;
        pll_locked = 1'b0;
        repeat (3) tick();
        check("reset_state", outs_reset(), 1);
        check("reset_hsync", int'(hsync), 1);
        rst = 1'b1;

        bad = 0;
        repeat (1000) begin
            tick();
            if (outs_reset() == 0) bad++;
        end
        check("idle_before_lock", bad, 0);

        pll_locked = 1'b1;
        wait_update(16, found);
        check("first_update_seen", found, 1);
        check("first_latency_phase", int'(pdiv), 3);
        check("first_hcount", int'(hcount), 0);
        check("first_vcount", int'(vcount), VA);
        check("first_de", int'(de), 0);
        check("first_frame_start", int'(frame_start), 0);
        wait_frame(2000, cycles);
        check("start_to_frame_clks", cycles, (VT - VA) * HT * 4);

        n_de = 0; n_hs = 0; n_vs = 0; n_ls = 0; n_fs = 0; n_rd = 0; n_hfall = 0; n_vfall = 0;
        bad_strobe = 0; bad_stable = 0; bad_de = 0; bad_hs = 0; bad_vs = 0; bad_fb = 0;
        bad_hfall = 0; bad_vfall = 0; last_fs = -1; fs_gap = -1;
        prev_hs = 1'b1; prev_vs = 1'b1;
        prev_vec = {hsync, vsync, de, fb_rd, hcount, vcount, fb_addr};
        observe();
        repeat (2 * VT * HT * 4 - 1) begin
            tick();
            observe();
        end
        check("de_pixels", n_de, 2 * HA * VA);
        check("fb_rd_pixels", n_rd, 2 * HA * VA);
        check("hsync_low_pixels", n_hs, 2 * VT * HS);
        check("vsync_low_pixels", n_vs, 2 * VS * HT);
        check("hsync_pulses", n_hfall, 2 * VT);
        check("vsync_pulses", n_vfall, 2);
        check("line_starts", n_ls, 2 * VT);
        check("frame_starts", n_fs, 2);
        check("frame_gap_clks", fs_gap, VT * HT * 4);
        check("strobe_shape", bad_strobe, 0);
        check("outputs_stable_in_pixel", bad_stable, 0);
        check("de_window", bad_de, 0);
        check("hsync_window", bad_hs, 0);
        check("vsync_window", bad_vs, 0);
        check("hsync_start_col", bad_hfall, 0);
        check("vsync_start_line", bad_vfall, 0);
        check("fetch_addr", bad_fb, 0);

        // Drop lock on the pix_ce cycle of display position (10,3).
        wait_pos(10, 3, 2, 4000, found);
        check("drop_pos_found", found, 1);
        pll_locked = 1'b0;
        tick();
        check("drop_reset_next_edge", outs_reset(), 1);
        bad = 0;
        repeat (9) begin
            tick();
            if (outs_reset() == 0) bad++;
        end
        check("drop_held_reset", bad, 0);
        pll_locked = 1'b1;
        wait_update(16, found);
        check("relock_update_seen", found, 1);
        check("relock_hcount", int'(hcount), 0);
        check("relock_vcount", int'(vcount), VA);
        check("relock_frame_start", int'(frame_start), 0);
        wait_frame(2000, cycles);
        check("relock_to_frame_clks", cycles, (VT - VA) * HT * 4);

        // Asynchronous reset on a pix_ce cycle in the middle of a visible line.
        wait_pos(5, 2, 2, 4000, found);
        check("rst_pos_found", found, 1);
        check("rst_pos_de", int'(de), 1);
        rst = 1'b0;
        #1;
        check("rst_async_reset", outs_reset(), 1);
        bad = 0;
        found = 0;
        for (int i = 0; i < 8 && found == 0; i++) begin
            tick();
            if (outs_reset() == 0) bad++;
            if (pdiv == 2'd0) found = 1;
        end
        rst = 1'b1;
        wait_update(16, found);
        check("rst_held_reset", bad, 0);
        check("post_rst_update_seen", found, 1);
        check("post_rst_phase", int'(pdiv), 3);
        check("post_rst_vcount", int'(vcount), VA);
        check("post_rst_hcount", int'(hcount), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
